// File: rtl/instruction_assembler.sv
// instruction_assembler: assembles a byte-serial stream into an IR_BYTES-wide instruction via a staging register.
// Define IR_PREFETCH_EN to allow a new fill while the current instruction is still unconsumed.
module instruction_assembler #(
  parameter int BYTE_W    = 8,
  parameter int IR_BYTES  = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_start,
  input  logic                             fetch_abort,
  input  logic [BYTE_W-1:0]                byte_in,
  input  logic                             byte_valid,
  output logic                             byte_ready,
  input  logic                             wr_en,
  input  logic [$clog2(IR_BYTES)-1:0]      wr_idx,
  input  logic [BYTE_W-1:0]                wr_data,
  input  logic                             ir_consume,
  output logic [IR_BYTES*BYTE_W-1:0]       ir_out,
  output logic                             ir_valid,
  output logic                             busy,
  output logic [$clog2(IR_BYTES+1)-1:0]    byte_cnt
);

  localparam int IR_W  = IR_BYTES * BYTE_W;
  localparam int CNT_W = $clog2(IR_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IR_BYTES - 1);

`ifdef IR_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IR_W-1:0]  stg_q, stg_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic             vld_q, vld_d;
  int               lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stg_q   <= '0;
      ir_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    lane    = (MSB_FIRST != 0) ? (IR_BYTES - 1 - int'(cnt_q)) : int'(cnt_q);

    if (vld_q && ir_consume)
      vld_d = 1'b0;
    if (wr_en && (int'(wr_idx) < IR_BYTES))
      ir_d[int'(wr_idx)*BYTE_W +: BYTE_W] = wr_data;

    if (fetch_abort) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        cnt_d   = '0;
        stg_d   = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_start && (!vld_q || PREFETCH)) begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
        FILL: begin
          if (byte_valid) begin
            stg_d[lane*BYTE_W +: BYTE_W] = byte_in;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT)
              state_d = FULL;
          end
        end
        FULL: begin
          // Transfer overrides both the consume-clear and any direct write above.
          if (!vld_q || ir_consume) begin
            ir_d    = stg_q;
            vld_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign byte_ready = (state_q == FILL);
  assign busy       = (state_q != IDLE);
  assign ir_out     = ir_q;
  assign ir_valid   = vld_q;
  assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_instruction_assembler.sv
// Bench for instruction_assembler: 2-byte MSB-first (A), 4-byte LSB-first (B), 3-byte write-only lane check (C).
module tb_instruction_assembler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_start, a_abort, a_bv, a_br, a_wr, a_cons, a_vld, a_busy;
  logic [7:0] a_byte, a_wd;
  logic [0:0] a_idx;
  logic [15:0] a_ir;
  logic [1:0] a_cnt;

  logic b_start, b_abort, b_bv, b_br, b_wr, b_cons, b_vld, b_busy;
  logic [7:0] b_byte, b_wd;
  logic [1:0] b_idx;
  logic [31:0] b_ir;
  logic [2:0] b_cnt;

  logic c_start, c_abort, c_cons, c_br, c_vld, c_busy;
  logic [23:0] c_ir;
  logic [1:0] c_cnt;

  instruction_assembler dut_a (
    .clk(clk), .rst(rst), .fetch_start(a_start), .fetch_abort(a_abort),
    .byte_in(a_byte), .byte_valid(a_bv), .byte_ready(a_br),
    .wr_en(a_wr), .wr_idx(a_idx), .wr_data(a_wd), .ir_consume(a_cons),
    .ir_out(a_ir), .ir_valid(a_vld), .busy(a_busy), .byte_cnt(a_cnt)
  );

  instruction_assembler #(.BYTE_W(8), .IR_BYTES(4), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .fetch_start(b_start), .fetch_abort(b_abort),
    .byte_in(b_byte), .byte_valid(b_bv), .byte_ready(b_br),
    .wr_en(b_wr), .wr_idx(b_idx), .wr_data(b_wd), .ir_consume(b_cons),
    .ir_out(b_ir), .ir_valid(b_vld), .busy(b_busy), .byte_cnt(b_cnt)
  );

  instruction_assembler #(.BYTE_W(8), .IR_BYTES(3), .MSB_FIRST(1)) dut_c (
    .clk(clk), .rst(rst), .fetch_start(c_start), .fetch_abort(c_abort),
    .byte_in(b_byte), .byte_valid(b_bv), .byte_ready(c_br),
    .wr_en(b_wr), .wr_idx(b_idx), .wr_data(b_wd), .ir_consume(c_cons),
    .ir_out(c_ir), .ir_valid(c_vld), .busy(c_busy), .byte_cnt(c_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq[$];

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic a_fill(input logic [7:0] x0, input logic [7:0] x1);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_byte  = x0;
    a_bv    = 1'b1;
    @(negedge clk);
    a_byte  = x1;
    @(negedge clk);
    a_bv    = 1'b0;
  endtask

  task automatic a_collect(input string name);
    logic [63:0] e;
    int unsigned n = 0;
    while (!a_vld && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!a_vld || sbq.size() == 0) begin
      chk({name, "_timeout"}, {63'd0, a_vld}, 64'd1);
      return;
    end
    e = sbq.pop_front();
    chk(name, {48'd0, a_ir}, e);
    a_cons = 1'b1;
    @(negedge clk);
    a_cons = 1'b0;
    chk({name, "_consumed"}, {63'd0, a_vld}, 64'd0);
  endtask

  initial begin
    logic [7:0] bb[4];
    logic [63:0] e;
    bb = '{8'h11, 8'h22, 8'h33, 8'h44};
    vt[0] = '{8'hA5, 8'h3C, 16'hA53C};
    vt[1] = '{8'h00, 8'hFF, 16'h00FF};
    vt[2] = '{8'hFF, 8'h01, 16'hFF01};
    vt[3] = '{8'h5A, 8'hC3, 16'h5AC3};

    rst = 1'b1;
    {a_start, a_abort, a_bv, a_wr, a_cons} = '0;
    {b_start, b_abort, b_bv, b_wr, b_cons} = '0;
    {c_start, c_abort, c_cons} = '0;
    a_byte = '0; a_wd = '0; a_idx = '0;
    b_byte = '0; b_wd = '0; b_idx = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ir", {48'd0, a_ir}, 64'd0);
    chk("rst_state", {60'd0, a_vld, a_br, a_busy, 1'b0}, 64'd0);
    chk("rst_cnt", {62'd0, a_cnt}, 64'd0);

    // First fill with per-edge latency checks
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("t2_fill_entry", {61'd0, a_br, a_busy, a_vld}, 64'b110);
    chk("t2_cnt0", {62'd0, a_cnt}, 64'd0);
    a_byte = 8'hA5; a_bv = 1'b1;
    @(negedge clk);
    chk("t2_cnt1", {62'd0, a_cnt}, 64'd1);
    a_byte = 8'h3C;
    @(negedge clk);
    a_bv = 1'b0;
    chk("t2_full", {61'd0, a_br, a_busy, a_vld}, 64'b010);
    chk("t2_cnt_full", {62'd0, a_cnt}, 64'd2);
    @(negedge clk);
    chk("t2_ir", {48'd0, a_ir}, 64'hA53C);
    chk("t2_vld_idle", {62'd0, a_vld, a_busy}, 64'b10);
    chk("t2_cnt_back", {62'd0, a_cnt}, 64'd0);

    // Direct lane writes keep ir_valid
    a_wr = 1'b1; a_idx = 1'b1; a_wd = 8'hFF;
    @(negedge clk);
    a_idx = 1'b0; a_wd = 8'h00;
    @(negedge clk);
    a_wr = 1'b0;
    chk("t5_ir", {48'd0, a_ir}, 64'hFF00);
    chk("t5_vld", {63'd0, a_vld}, 64'd1);

    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
`ifdef IR_PREFETCH_EN
    chk("t6_pf_busy", {63'd0, a_busy}, 64'd1);
    a_byte = 8'h22; a_bv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_bv = 1'b0;
    @(negedge clk);
    chk("t6_pf_hold", {61'd0, a_br, a_busy, a_vld}, 64'b011);
    chk("t6_pf_old_ir", {48'd0, a_ir}, 64'hFF00);
    a_cons = 1'b1;
    @(negedge clk);
    a_cons = 1'b0;
    chk("t6_pf_new_ir", {48'd0, a_ir}, 64'h2222);
    chk("t6_pf_vld", {62'd0, a_vld, a_busy}, 64'b10);
    a_cons = 1'b1;
    @(negedge clk);
    a_cons = 1'b0;
    chk("t6_pf_cleared", {63'd0, a_vld}, 64'd0);
`else
    chk("t6_start_ignored", {63'd0, a_busy}, 64'd0);
    a_cons = 1'b1;
    @(negedge clk);
    a_cons = 1'b0;
    chk("t6_consume_vld", {63'd0, a_vld}, 64'd0);
    chk("t6_consume_ir", {48'd0, a_ir}, 64'hFF00);
`endif

    for (int i = 0; i < 4; i++) begin
      a_fill(vt[i].b0, vt[i].b1);
      sbq.push_back({48'd0, vt[i].exp});
      a_collect($sformatf("vec%0d", i));
    end

    // Abort after one byte, then a clean fill whose transfer edge collides with a direct write
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_byte = 8'h99; a_bv = 1'b1;
    @(negedge clk);
    a_bv = 1'b0;
    chk("t4_cnt1", {62'd0, a_cnt}, 64'd1);
    a_abort = 1'b1; a_bv = 1'b1; a_byte = 8'hEE;
    @(negedge clk);
    a_abort = 1'b0; a_bv = 1'b0;
    chk("t4_aborted", {60'd0, a_busy, a_vld, a_cnt}, 64'd0);
    sbq.push_back(64'h1234);
    a_fill(8'h12, 8'h34);
    a_wr = 1'b1; a_idx = 1'b0; a_wd = 8'h77;
    @(negedge clk);
    a_wr = 1'b0;
    a_collect("t4_ir_wr_dropped");

    // Abort while FULL beats the pending transfer
    a_fill(8'h56, 8'h78);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("abort_full_state", {62'd0, a_busy, a_vld}, 64'd0);
    chk("abort_full_ir", {48'd0, a_ir}, 64'h1234);

    // Reset in the middle of a fill
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_byte = 8'h9A; a_bv = 1'b1;
    @(negedge clk);
    a_bv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t1_ir", {48'd0, a_ir}, 64'd0);
    chk("t1_flags", {61'd0, a_vld, a_br, a_busy}, 64'd0);
    chk("t1_cnt", {62'd0, a_cnt}, 64'd0);

    // LSB-first 4-byte fill with bubbles between bytes
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("t3_cnt0", {61'd0, b_cnt}, 64'd0);
    sbq.push_back(64'h44332211);
    for (int i = 0; i < 4; i++) begin
      b_bv = 1'b0;
      @(negedge clk);
      chk($sformatf("t3_gap%0d", i), {61'd0, b_cnt}, 64'(i));
      b_byte = bb[i]; b_bv = 1'b1;
      @(negedge clk);
      b_bv = 1'b0;
      chk($sformatf("t3_cnt%0d", i + 1), {61'd0, b_cnt}, 64'(i + 1));
    end
    @(negedge clk);
    chk("t3_cnt_back", {61'd0, b_cnt}, 64'd0);
    if (sbq.size() == 0) chk("t3_sb_empty", 64'd0, 64'd1);
    else begin
      e = sbq.pop_front();
      chk("t3_ir", {32'd0, b_ir}, e);
    end
    chk("t3_vld", {63'd0, b_vld}, 64'd1);

    // Lane 3 is out of range for the 3-byte instance
    b_wr = 1'b1; b_idx = 2'd3; b_wd = 8'hAB;
    @(negedge clk);
    chk("wr_b_lane3", {32'd0, b_ir}, 64'hAB332211);
    chk("wr_c_ignored", {40'd0, c_ir}, 64'd0);
    b_idx = 2'd2; b_wd = 8'hCD;
    @(negedge clk);
    b_wr = 1'b0;
    chk("wr_b_lane2", {32'd0, b_ir}, 64'hABCD2211);
    chk("wr_c_lane2", {40'd0, c_ir}, 64'hCD0000);
    chk("wr_vld_kept", {62'd0, b_vld, c_vld}, 64'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
